xorshift_rewinder: RTL and testbench
====================================

Name: xorshift_rewinder

Overview:
- Inverse of the 32-bit xorshift generator (x ^= x<<13; x ^= x>>17; x ^= x<<5): takes a generator state and walks the sequence backwards by a requested number of steps.
- Sequential, one partial-inversion iteration per clock; valid/ready on both sides.
- Sits beside the forward generator for sequence replay, seed recovery and self-checking of generated streams.

Parameters:
- SHIFT_A, 13, first forward shift (left)
- SHIFT_B, 17, second forward shift (right)
- SHIFT_C, 5, third forward shift (left)
- STEP_W, 16, width of the per-request step count

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  block can accept a request
- in_state  in  32  generator state to rewind
- in_steps  in  STEP_W  number of backward steps (0 = pass-through)
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_state  out  32  state in_steps positions earlier in the sequence
- busy  out  1  high from acceptance until the result handshake completes

Behaviour:
- Reset (async, rst=1): FSM to IDLE; in_ready=1, out_valid=0, out_state=0, busy=0. Internal y, t and counters cleared. An in-flight request is discarded with no output.
- States: IDLE, UNDO_C, UNDO_B, UNDO_A, DONE.
- IDLE: in_ready=1. On in_valid, capture in_state into y and t, and capture in_steps. Go to UNDO_C if steps≠0, otherwise go to DONE with out_state=in_state.
- UNDO_k: t <= y ^ shift_k(t) each cycle. shift_k is << for A and C, >> for B. Run N_k = ceil(32/k)-1 cycles: C=6, B=1, A=2.
- Stage exit: y <= final t, then move to the next stage in order C→B→A.
- End of UNDO_A: decrement the step counter. Loop to UNDO_C if it is nonzero, otherwise go to DONE with out_state=result.
- Latency: out_valid rises 9*steps+1 clocks after the accepting edge; steps=0 gives 1 clock. Cycle count is fixed and independent of data.
- DONE: out_valid=1, and out_state is held stable until out_ready. On the handshake go to IDLE, so in_ready returns the next cycle.
- At most one request in flight. in_ready=0 in every state other than IDLE.
- Backpressure in DONE is unlimited. out_state and out_valid must not change while waiting.
- State 0 rewinds to 0 for any step count. It is not flagged as an error.
- Steps counter width is STEP_W, so the maximum request is 2^STEP_W-1 steps. There is no wrap inside a request.
- All arithmetic is 32-bit unsigned. Shifted-out bits are dropped and shifted-in bits are 0.
- Inputs are ignored while in_ready=0.

Decomposition:
- Package xorshift_pkg holds:
  - the state width constant (32) and the SHIFT_A/B/C defaults;
  - derived iteration counts N_A/N_B/N_C;
  - the FSM state enum.
- The forward generator shares the same shift constants from this package.
- Sub-module xorshift_unshift_iter: combinational, one iteration t_next = y ^ (dir ? t>>k : t<<k), instantiated once and muxed by stage.

Test Plan:
- in_state=0x00042021, steps=1, out_ready=1 -> out_state=0x00000001, out_valid exactly 10 clocks after acceptance.
- in_state=0x04080601, steps=2 -> out_state=0x00000001 after 19 clocks; busy high throughout, in_ready low until the handshake.
- in_state=0xDEADBEEF, steps=0 -> out_state=0xDEADBEEF, 1-clock latency.
- in_state=0, steps=5 -> out_state=0 after 46 clocks.
- steps=1 on 0x00042021, out_ready held low 5 cycles after out_valid -> out_state stays 0x00000001 and in_ready stays 0; completes on the out_ready pulse; new request accepted the cycle after.
- rst pulsed during UNDO_B of a steps=3 request -> out_valid never asserts and outputs read 0. A following steps=N request on forward-model outputs from seed 20240301 (N=1..8) must return 20240301.

Source files
------------

// File: rtl/xorshift_pkg.sv
// Shared constants, derived iteration counts and FSM encoding for the xorshift
// generator family (forward generator and rewinder use the same shifts).
package xorshift_pkg;

  localparam int unsigned STATE_W      = 32;
  localparam int unsigned SHIFT_A_DFLT = 13;
  localparam int unsigned SHIFT_B_DFLT = 17;
  localparam int unsigned SHIFT_C_DFLT = 5;
  localparam int unsigned STEP_W_DFLT  = 16;
  localparam int unsigned SHAMT_W      = $clog2(STATE_W);

  // Iterations of t = y ^ shift(t) needed to undo one x ^= shift(x) stage.
  function automatic int unsigned iter_count(input int unsigned k);
    return (STATE_W + k - 1) / k - 1;
  endfunction

  localparam int unsigned N_A = iter_count(SHIFT_A_DFLT);
  localparam int unsigned N_B = iter_count(SHIFT_B_DFLT);
  localparam int unsigned N_C = iter_count(SHIFT_C_DFLT);

  typedef enum logic [2:0] {
    IDLE,
    UNDO_C,
    UNDO_B,
    UNDO_A,
    DONE
  } state_e;

endpackage

// File: rtl/xorshift_unshift_iter.sv
// One partial-inversion iteration: t_next = y ^ (t shifted by shamt).
module xorshift_unshift_iter
  import xorshift_pkg::*;
#(
  parameter int unsigned W = STATE_W
) (
  input  logic [W-1:0]         y,
  input  logic [W-1:0]         t,
  input  logic [$clog2(W)-1:0] shamt,
  input  logic                 dir,
  output logic [W-1:0]         t_next_c
);

  // dir=1 undoes a right-shift stage, dir=0 a left-shift stage.
  always_comb begin
    t_next_c = y ^ (dir ? (t >> shamt) : (t << shamt));
  end

endmodule

// File: rtl/xorshift_rewinder.sv
// Walks a 32-bit xorshift sequence backwards by a requested number of steps,
// one inversion iteration per clock, undoing stages in order C, B, A.
module xorshift_rewinder
  import xorshift_pkg::*;
#(
  parameter int unsigned SHIFT_A = SHIFT_A_DFLT,
  parameter int unsigned SHIFT_B = SHIFT_B_DFLT,
  parameter int unsigned SHIFT_C = SHIFT_C_DFLT,
  parameter int unsigned STEP_W  = STEP_W_DFLT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  input  logic [STEP_W-1:0]  in_steps,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output logic               busy
);

  localparam int unsigned ITER_W = SHAMT_W;
  localparam int unsigned ITER_A = iter_count(SHIFT_A);
  localparam int unsigned ITER_B = iter_count(SHIFT_B);
  localparam int unsigned ITER_C = iter_count(SHIFT_C);

  state_e              state_q, state_d;
  logic [STATE_W-1:0]  y_q, y_d;
  logic [STATE_W-1:0]  t_q, t_d;
  logic [STEP_W-1:0]   steps_q, steps_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [STATE_W-1:0]  out_state_q, out_state_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;

  logic [SHAMT_W-1:0]  shamt_c;
  logic                dir_c;
  logic [STATE_W-1:0]  t_next_c;

  // Select the shift amount and direction of the stage being undone.
  always_comb begin
    shamt_c = SHAMT_W'(SHIFT_C);
    dir_c   = 1'b0;
    unique case (state_q)
      UNDO_B: begin
        shamt_c = SHAMT_W'(SHIFT_B);
        dir_c   = 1'b1;
      end
      UNDO_A: begin
        shamt_c = SHAMT_W'(SHIFT_A);
        dir_c   = 1'b0;
      end
      default: begin
        shamt_c = SHAMT_W'(SHIFT_C);
        dir_c   = 1'b0;
      end
    endcase
  end

  xorshift_unshift_iter #(
    .W(STATE_W)
  ) u_iter (
    .y        (y_q),
    .t        (t_q),
    .shamt    (shamt_c),
    .dir      (dir_c),
    .t_next_c (t_next_c)
  );

  // Next-state logic: stage sequencing, iteration/step counting, result capture.
  always_comb begin
    state_d     = state_q;
    y_d         = y_q;
    t_d         = t_q;
    steps_d     = steps_q;
    iter_d      = iter_q;
    out_state_d = out_state_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          y_d     = in_state;
          t_d     = in_state;
          steps_d = in_steps;
          iter_d  = '0;
          if (in_steps != '0) begin
            state_d = UNDO_C;
          end else begin
            state_d     = DONE;
            out_state_d = in_state;
          end
        end
      end
      UNDO_C: begin
        t_d = t_next_c;
        if (iter_q == ITER_W'(ITER_C - 1)) begin
          y_d     = t_next_c;
          iter_d  = '0;
          state_d = UNDO_B;
        end else begin
          iter_d = iter_q + ITER_W'(1);
        end
      end
      UNDO_B: begin
        t_d = t_next_c;
        if (iter_q == ITER_W'(ITER_B - 1)) begin
          y_d     = t_next_c;
          iter_d  = '0;
          state_d = UNDO_A;
        end else begin
          iter_d = iter_q + ITER_W'(1);
        end
      end
      UNDO_A: begin
        t_d = t_next_c;
        if (iter_q == ITER_W'(ITER_A - 1)) begin
          y_d     = t_next_c;
          iter_d  = '0;
          steps_d = steps_q - STEP_W'(1);
          if (steps_q == STEP_W'(1)) begin
            state_d     = DONE;
            out_state_d = t_next_c;
          end else begin
            state_d = UNDO_C;
          end
        end else begin
          iter_d = iter_q + ITER_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      y_q         <= '0;
      t_q         <= '0;
      steps_q     <= '0;
      iter_q      <= '0;
      out_state_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      t_q         <= t_d;
      steps_q     <= steps_d;
      iter_q      <= iter_d;
      out_state_q <= out_state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_state = out_state_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_xorshift_rewinder.sv
// Bench for xorshift_rewinder: a forward-generator reference model checks every
// result, and a per-cycle monitor checks handshake timing and output stability.
module tb_xorshift_rewinder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_state = '0;
  logic [15:0] in_steps = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_state;
  logic        busy;

  int checks = 0;
  int errors = 0;

  xorshift_rewinder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_steps  (in_steps),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Forward xorshift step straight from the generator definition.
  function automatic logic [31:0] fwd(input logic [31:0] x);
    logic [31:0] v;
    v = x;
    v = v ^ (v << 13);
    v = v ^ (v >> 17);
    v = v ^ (v << 5);
    return v;
  endfunction

  function automatic logic [31:0] fwd_n(input logic [31:0] x, input int n);
    logic [31:0] v;
    v = x;
    for (int i = 0; i < n; i++) v = fwd(v);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle monitor: acceptance tracking, latency, busy/in_ready and hold checks.
  bit          m_busy = 1'b0;
  int          m_cnt, m_lat, m_steps;
  logic [31:0] m_state, m_hold;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out_state", out_state, 32'd0);
      m_busy = 1'b0;
    end else if (!m_busy) begin
      check("idle_in_ready", 32'(in_ready), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_out_valid", 32'(out_valid), 32'd0);
      if (in_valid) begin
        m_busy  = 1'b1;
        m_cnt   = 0;
        m_state = in_state;
        m_steps = int'(in_steps);
        m_lat   = 9 * int'(in_steps) + 1;
      end
    end else begin
      m_cnt++;
      check("run_busy", 32'(busy), 32'd1);
      check("run_in_ready", 32'(in_ready), 32'd0);
      check("out_valid_timing", 32'(out_valid), 32'(m_cnt >= m_lat));
      if (m_cnt == m_lat) begin
        check("model_rewind", fwd_n(out_state, m_steps), m_state);
        m_hold = out_state;
      end else if (m_cnt > m_lat) begin
        check("out_state_hold", out_state, m_hold);
      end
      if (m_cnt >= m_lat && out_ready) m_busy = 1'b0;
    end
  end

  // Issue one request; dly<0 keeps out_ready high throughout, else stall dly cycles.
  task automatic run_req(input logic [31:0] st, input logic [15:0] n, input int dly,
                         output logic [31:0] res);
    int guard;
    res   = '0;
    guard = 0;
    while (!in_ready && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    in_valid  = 1'b1;
    in_state  = st;
    in_steps  = n;
    out_ready = (dly < 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard    = 0;
    while (!out_valid && guard < 9 * int'(n) + 20) begin
      in_valid = 1'($urandom);
      in_state = $urandom;
      in_steps = 16'($urandom);
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      check("result_timeout", 32'd0, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b0;
      return;
    end
    res = out_state;
    if (dly > 0) begin
      repeat (dly) begin
        @(posedge clk); #1;
        check("bp_out_state", out_state, res);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [31:0] res, seed, st;
  int          n, dly;

  initial begin
    // Pin the reference model to hand-computed values.
    check("model_fwd1", fwd(32'h00000001), 32'h00042021);
    check("model_fwd2", fwd_n(32'h00000001, 2), 32'h04080601);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    run_req(32'h00042021, 16'd1, -1, res);
    check("vec_steps1", res, 32'h00000001);
    run_req(32'h04080601, 16'd2, -1, res);
    check("vec_steps2", res, 32'h00000001);
    run_req(32'hDEADBEEF, 16'd0, -1, res);
    check("vec_steps0", res, 32'hDEADBEEF);
    run_req(32'h00000000, 16'd5, 0, res);
    check("vec_zero", res, 32'h00000000);
    run_req(32'h00042021, 16'd1, 5, res);
    check("vec_backpressure", res, 32'h00000001);
    run_req(32'hDEADBEEF, 16'd0, 0, res);
    check("vec_back_to_back", res, 32'hDEADBEEF);

    // Reset during UNDO_B of a 3-step request discards it.
    in_valid = 1'b1;
    in_state = 32'h12345678;
    in_steps = 16'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    #2;
    check("midrst_out_state", out_state, 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("midrst_no_result", 32'(out_valid), 32'd0);
    check("midrst_state_zero", out_state, 32'd0);

    // Sequence replay from a known seed.
    for (int k = 1; k <= 8; k++) begin
      run_req(fwd_n(32'd20240301, k), 16'(k), k % 3 - 1, res);
      check("seed_replay", res, 32'd20240301);
    end

    // Randomized requests against the forward model.
    for (int k = 0; k < 24; k++) begin
      seed = $urandom;
      n    = int'($urandom_range(0, 20));
      dly  = int'($urandom_range(0, 3)) - 1;
      st   = fwd_n(seed, n);
      run_req(st, 16'(n), dly, res);
      check("rand_rewind", res, seed);
    end

    // One long request.
    seed = 32'hC0FFEE11;
    run_req(fwd_n(seed, 300), 16'd300, 1, res);
    check("long_rewind", res, seed);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
